output_mixer: RTL and testbench
===============================

OUTPUT_MIXER -- requirements
Module: output_mixer

Interface
REQ-001 Parameter OUT_WIDTH, default 14: width of the signed two's-complement mix outputs.
REQ-002 Parameter RHYTHM_SHIFT, default 1: left-shift gain applied to each rhythm slot value before accumulation.
REQ-003 clk  input  1  clock, all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 clkena  input  1  advance enable; with clkena low, no state changes except the REQ-019 mix_valid clear.
REQ-006 slot  input  5  current operator slot, 0..17, even = modulator, odd = carrier, channel = slot/2.
REQ-007 stage  input  2  sub-step 0..3 within a slot; the slot advances after stage 3.
REQ-008 rhythm  input  1  rhythm-mode flag.
REQ-009 maddr  output  5  read address into the per-slot output memory.
REQ-010 mdata  input  10  memory read data; bit 9 = sign, bits 8:0 = magnitude 0..511.
REQ-011 mix_melody  output  OUT_WIDTH  signed melody sum of the last complete frame.
REQ-012 mix_rhythm  output  OUT_WIDTH  signed rhythm sum of the last complete frame.
REQ-013 mix_valid  output  1  one-clk pulse when the mix outputs update.

Function
REQ-014 On a clkena cycle with stage==0, maddr SHALL be loaded with slot; the memory returns mdata by the stage==2 clkena cycle of the same slot.
REQ-015 mdata SHALL be sampled on the clkena cycle with stage==2 and converted to signed value v = sign ? -magnitude : +magnitude; negative zero SHALL yield 0.
REQ-016 Slot routing SHALL use the frame rhythm flag fr. With fr=0, odd slots add v to the melody accumulator and even slots are ignored. With fr=1, odd slots 1..11 add v to melody; slots 13, 14, 15, 16, 17 add v<<RHYTHM_SHIFT to rhythm; slots 0..12 even are ignored.
REQ-017 fr SHALL be latched from rhythm on the clkena cycle with slot==0, stage==0 and held for the whole frame; rhythm changes mid-frame take effect only at the next frame.
REQ-018 Accumulators SHALL be signed, at least OUT_WIDTH+2 bits wide, with no internal overflow for 9 x 511 x 2^RHYTHM_SHIFT.
REQ-019 On the clkena cycle with slot==17, stage==3, if frame_ok==1 the block SHALL do the following. Load mix_melody and mix_rhythm from the accumulators saturated to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]. Set mix_valid=1 for exactly one clk, cleared on the next clk edge whether or not clkena is high.
REQ-020 On that same slot==17, stage==3 clkena cycle, both accumulators SHALL clear to 0 regardless of frame_ok.
REQ-021 frame_ok SHALL be set at the slot==0, stage==0 clkena cycle and cleared by reset. A frame whose sweep did not start at slot 0 SHALL be discarded: outputs are held and no mix_valid is issued.
REQ-022 Mix latency: a value written to memory in frame N SHALL appear in the mix outputs at the end of frame N+1.
REQ-023 Slot values above 17 SHALL be ignored: no accumulation and no frame end.
REQ-024 Outputs SHALL hold their values between mix_valid pulses.

Reset
REQ-025 Reset SHALL set mix_melody=0, mix_rhythm=0, mix_valid=0, maddr=0, accumulators=0, fr=0, frame_ok=0.
REQ-026 Reset asserted mid-frame SHALL discard the partial frame; the first mix_valid after release SHALL follow the first full slot 0..17 sweep.

Verification
REQ-027 Melody sum: fr=0, odd slots mdata=+100, even slots mdata=+511 -> mix_melody=900, mix_rhythm=0, one mix_valid pulse.
REQ-028 Rhythm routing: fr=1, slots 1..11 odd =+10, slots 13..17 =+20, slot 12 =+500 -> mix_melody=60, mix_rhythm=200.
REQ-029 Sign handling: fr=0, odd slots alternate -511/+511 starting at slot 1 -> mix_melody=-511; also mdata=10'h200 (negative zero) on all slots -> mix_melody=0.
REQ-030 Saturation: OUT_WIDTH=12, fr=0, all odd slots -511 -> mix_melody=-2048 (sum -4599 clipped).
REQ-031 Mid-frame control: rhythm toggled 0->1 at slot 7 -> the current frame routes all odd slots to melody; the next frame applies rhythm routing.
REQ-032 Reset/clkena: reset released at slot 9 -> no mix_valid until the end of the next full frame; clkena held low for 50 clks mid-frame -> accumulators and outputs unchanged and the result equals the uninterrupted result.

Source files
------------

// File: rtl/output_mixer.sv
// Output mixer: walks the 18 operator slots of each frame, sums the per-slot output
// samples into melody and rhythm accumulators, and publishes a saturated mix per frame.
module output_mixer #(
  parameter int OUT_WIDTH    = 14,
  parameter int RHYTHM_SHIFT = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clkena,
  input  logic [4:0]                  slot,
  input  logic [1:0]                  stage,
  input  logic                        rhythm,
  output logic [4:0]                  maddr,
  input  logic [9:0]                  mdata,
  output logic signed [OUT_WIDTH-1:0] mix_melody,
  output logic signed [OUT_WIDTH-1:0] mix_rhythm,
  output logic                        mix_valid
);

  // 9 x 511 fits in 13 magnitude bits; add the rhythm gain and a sign bit.
  localparam int SUM_W = 14 + RHYTHM_SHIFT;
  localparam int ACC_W = (OUT_WIDTH + 2 > SUM_W) ? OUT_WIDTH + 2 : SUM_W;
  localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] OUT_MIN = ACC_W'(-(64'sd1 <<< (OUT_WIDTH - 1)));

  function automatic logic signed [ACC_W-1:0] mag_to_signed(input logic [9:0] d);
    logic signed [ACC_W-1:0] m;
    m = {{(ACC_W-9){1'b0}}, d[8:0]};
    return d[9] ? -m : m;
  endfunction

  function automatic logic signed [OUT_WIDTH-1:0] saturate(input logic signed [ACC_W-1:0] a);
    if (a > OUT_MAX) begin
      return OUT_MAX[OUT_WIDTH-1:0];
    end else if (a < OUT_MIN) begin
      return OUT_MIN[OUT_WIDTH-1:0];
    end else begin
      return a[OUT_WIDTH-1:0];
    end
  endfunction

  logic [4:0]              maddr_q, maddr_d;
  logic                    fr_q, fr_d;
  logic                    frame_ok_q, frame_ok_d;
  logic signed [ACC_W-1:0] acc_mel_q, acc_mel_d;
  logic signed [ACC_W-1:0] acc_rhy_q, acc_rhy_d;
  logic signed [OUT_WIDTH-1:0] mix_mel_q, mix_mel_d;
  logic signed [OUT_WIDTH-1:0] mix_rhy_q, mix_rhy_d;
  logic                    mix_valid_q, mix_valid_d;

  logic                    slot_ok;
  logic                    frame_start;
  logic                    sample;
  logic                    frame_end;
  logic                    to_melody;
  logic                    to_rhythm;
  logic signed [ACC_W-1:0] sample_v;

  // Slot decode and accumulation
  always_comb begin
    slot_ok     = (slot <= 5'd17);
    frame_start = clkena && (stage == 2'd0) && (slot == 5'd0);
    sample      = clkena && (stage == 2'd2) && slot_ok;
    frame_end   = clkena && (stage == 2'd3) && (slot == 5'd17);
    // In rhythm mode the last five slots belong to the percussion channels.
    to_melody   = slot[0] && (!fr_q || (slot <= 5'd11));
    to_rhythm   = fr_q && (slot >= 5'd13);
    sample_v    = mag_to_signed(mdata);

    maddr_d     = maddr_q;
    fr_d        = fr_q;
    frame_ok_d  = frame_ok_q;
    acc_mel_d   = acc_mel_q;
    acc_rhy_d   = acc_rhy_q;
    mix_mel_d   = mix_mel_q;
    mix_rhy_d   = mix_rhy_q;
    mix_valid_d = 1'b0;

    if (clkena && (stage == 2'd0)) begin
      maddr_d = slot;
    end
    if (frame_start) begin
      fr_d       = rhythm;
      frame_ok_d = 1'b1;
    end
    if (sample && to_melody) begin
      acc_mel_d = acc_mel_q + sample_v;
    end
    if (sample && to_rhythm) begin
      acc_rhy_d = acc_rhy_q + (sample_v <<< RHYTHM_SHIFT);
    end

    // Frame end: publish only frames swept from slot 0, always restart the sums
    if (frame_end) begin
      acc_mel_d  = '0;
      acc_rhy_d  = '0;
      frame_ok_d = 1'b0;
      if (frame_ok_q) begin
        mix_mel_d   = saturate(acc_mel_q);
        mix_rhy_d   = saturate(acc_rhy_q);
        mix_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      maddr_q     <= '0;
      fr_q        <= 1'b0;
      frame_ok_q  <= 1'b0;
      acc_mel_q   <= '0;
      acc_rhy_q   <= '0;
      mix_mel_q   <= '0;
      mix_rhy_q   <= '0;
      mix_valid_q <= 1'b0;
    end else begin
      maddr_q     <= maddr_d;
      fr_q        <= fr_d;
      frame_ok_q  <= frame_ok_d;
      acc_mel_q   <= acc_mel_d;
      acc_rhy_q   <= acc_rhy_d;
      mix_mel_q   <= mix_mel_d;
      mix_rhy_q   <= mix_rhy_d;
      mix_valid_q <= mix_valid_d;
    end
  end

  assign maddr      = maddr_q;
  assign mix_melody = mix_mel_q;
  assign mix_rhythm = mix_rhy_q;
  assign mix_valid  = mix_valid_q;

endmodule

// File: tb/tb_output_mixer.sv
// Bench for output_mixer: table of frame patterns plus hand-written control sequences,
// with a scoreboard of expected mixes popped on each mix_valid pulse.
module tb_output_mixer;

  typedef struct packed {
    logic               fr;
    logic [17:0][9:0]   md;
    logic signed [31:0] mel;
    logic signed [31:0] rhy;
    logic signed [31:0] mel12;
    logic signed [31:0] rhy12;
  } vec_t;

  typedef struct {
    int mel;
    int rhy;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic clkena;
  logic [4:0] slot;
  logic [1:0] stage;
  logic rhythm;
  logic [4:0] maddr, maddr12;
  logic [9:0] mdata, mdata12;
  logic signed [13:0] mix_melody, mix_rhythm;
  logic signed [11:0] mel12, rhy12;
  logic mix_valid, valid12;
  logic [17:0][9:0] cur_md;

  int   n_vec = 0;
  int   n_mis = 0;
  exp_t sbq[$];
  int   last_mel = 0;
  int   last_rhy = 0;
  logic prev_valid = 1'b0;
  vec_t vecs[9];

  always #5 clk = ~clk;

  output_mixer dut (
    .clk(clk), .reset(reset), .clkena(clkena), .slot(slot), .stage(stage),
    .rhythm(rhythm), .maddr(maddr), .mdata(mdata), .mix_melody(mix_melody),
    .mix_rhythm(mix_rhythm), .mix_valid(mix_valid)
  );

  output_mixer #(.OUT_WIDTH(12), .RHYTHM_SHIFT(1)) dut12 (
    .clk(clk), .reset(reset), .clkena(clkena), .slot(slot), .stage(stage),
    .rhythm(rhythm), .maddr(maddr12), .mdata(mdata12), .mix_melody(mel12),
    .mix_rhythm(rhy12), .mix_valid(valid12)
  );

  // Per-slot output memory; addresses past the last slot read a nonzero pattern.
  always_comb begin
    mdata   = (maddr <= 5'd17) ? cur_md[maddr] : 10'h1FF;
    mdata12 = (maddr12 <= 5'd17) ? cur_md[maddr12] : 10'h1FF;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mix_valid) begin
      exp_t e;
      chk("valid_width", int'(prev_valid), 0);
      if (sbq.size() == 0) begin
        n_vec++;
        n_mis++;
        $display("FAIL unexpected_valid: got pulse mel=%0d rhy=%0d, required no pulse",
                 mix_melody, mix_rhythm);
      end else begin
        e = sbq.pop_front();
        last_mel = e.mel;
        last_rhy = e.rhy;
        chk("sb_melody", int'(mix_melody), e.mel);
        chk("sb_rhythm", int'(mix_rhythm), e.rhy);
      end
    end
    prev_valid = mix_valid;
  end

  function automatic logic [17:0][9:0] mk(input logic [9:0] odd, input logic [9:0] even,
                                          input bit alt);
    logic [17:0][9:0] md;
    for (int s = 0; s < 18; s++) begin
      if (s % 2 == 1) md[s] = (alt && ((s / 2) % 2 == 1)) ? {~odd[9], odd[8:0]} : odd;
      else            md[s] = even;
    end
    return md;
  endfunction

  function automatic logic [17:0][9:0] with_tail(input logic [17:0][9:0] md_in,
                                                 input logic [9:0] s12, input logic [9:0] t);
    logic [17:0][9:0] md;
    md = md_in;
    md[12] = s12;
    for (int s = 13; s < 18; s++) md[s] = t;
    return md;
  endfunction

  function automatic vec_t mkvec(input logic fr, input logic [17:0][9:0] md,
                                 input int mel, input int rhy, input int mel12, input int rhy12);
    vec_t v;
    v.fr = fr; v.md = md; v.mel = mel; v.rhy = rhy; v.mel12 = mel12; v.rhy12 = rhy12;
    return v;
  endfunction

  function automatic void model(input logic [17:0][9:0] md, input logic fr, input int ow,
                                output int mel, output int rhy);
    int v, lim;
    mel = 0;
    rhy = 0;
    for (int s = 0; s < 18; s++) begin
      v = md[s][9] ? -int'(md[s][8:0]) : int'(md[s][8:0]);
      if ((s % 2 == 1) && (!fr || s <= 11)) mel += v;
      if (fr && s >= 13) rhy += v * 2;
    end
    lim = 1 << (ow - 1);
    if (mel > lim - 1) mel = lim - 1;
    if (mel < -lim)    mel = -lim;
    if (rhy > lim - 1) rhy = lim - 1;
    if (rhy < -lim)    rhy = -lim;
  endfunction

  task automatic push_exp(input int mel, input int rhy);
    exp_t e;
    e.mel = mel;
    e.rhy = rhy;
    sbq.push_back(e);
  endtask

  task automatic step(input logic [4:0] s, input logic [1:0] st, input logic ce, input logic rh);
    slot = s; stage = st; clkena = ce; rhythm = rh;
    @(posedge clk);
    #1;
  endtask

  task automatic do_gap();
    logic [4:0] gs;
    for (int i = 0; i < 50; i++) begin
      case (i % 3)
        0:       gs = 5'd0;
        1:       gs = 5'd17;
        default: gs = 5'($urandom_range(0, 31));
      endcase
      step(gs, 2'(i % 4), 1'b0, 1'(i % 2));
    end
    chk("gap_hold_mel", int'(mix_melody), last_mel);
    chk("gap_hold_rhy", int'(mix_rhythm), last_rhy);
  endtask

  task automatic run_frame(input int first, input int last, input logic rh0,
                           input int tog, input int gap);
    logic rh;
    for (int s = first; s <= last; s++) begin
      for (int st = 0; st < 4; st++) begin
        rh = (s >= tog) ? ~rh0 : rh0;
        step(5'(s), 2'(st), 1'b1, rh);
        if (s == gap && st == 0) do_gap();
      end
    end
  endtask

  initial begin
    int m, r, m12, r12;
    logic frr;
    reset = 1'b1; clkena = 1'b0; slot = '0; stage = '0; rhythm = 1'b0; cur_md = '0;

    vecs[0] = mkvec(1'b0, mk(10'd100, 10'h1FF, 1'b0), 900, 0, 900, 0);
    vecs[1] = mkvec(1'b1, with_tail(mk(10'd10, 10'd0, 1'b0), 10'd500, 10'd20), 60, 200, 60, 200);
    vecs[2] = mkvec(1'b0, mk(10'h3FF, 10'd0, 1'b1), -511, 0, -511, 0);
    vecs[3] = mkvec(1'b0, mk(10'h200, 10'h200, 1'b0), 0, 0, 0, 0);
    vecs[4] = mkvec(1'b0, mk(10'h1FF, 10'h3FF, 1'b0), 4599, 0, 2047, 0);
    vecs[5] = mkvec(1'b1, mk(10'h1FF, 10'h1FF, 1'b0), 3066, 5110, 2047, 2047);
    vecs[6] = mkvec(1'b1, mk(10'h3FF, 10'h3FF, 1'b0), -3066, -5110, -2048, -2048);
    vecs[7] = mkvec(1'b0, mk(10'h3FF, 10'd0, 1'b0), -4599, 0, -2048, 0);
    vecs[8] = mkvec(1'b1, mk(10'h3FF, 10'd0, 1'b1), 0, -1022, 0, -1022);

    repeat (3) @(posedge clk);
    #1;
    chk("reset_mel", int'(mix_melody), 0);
    chk("reset_rhy", int'(mix_rhythm), 0);
    chk("reset_valid", int'(mix_valid), 0);
    chk("reset_maddr", int'(maddr), 0);
    reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      cur_md = vecs[i].md;
      push_exp(vecs[i].mel, vecs[i].rhy);
      run_frame(0, 17, vecs[i].fr, 99, 99);
      chk($sformatf("vec%0d_sat_mel", i), int'(mel12), vecs[i].mel12);
      chk($sformatf("vec%0d_sat_rhy", i), int'(rhy12), vecs[i].rhy12);
    end

    // Slots past 17 must neither accumulate nor end a frame.
    cur_md = vecs[0].md;
    run_frame(18, 31, 1'b0, 99, 99);
    push_exp(900, 0);
    run_frame(0, 17, 1'b0, 99, 99);

    // Rhythm raised at slot 7 only affects the following frame.
    cur_md = vecs[1].md;
    push_exp(120, 0);
    run_frame(0, 17, 1'b0, 7, 99);
    push_exp(60, 200);
    run_frame(0, 17, 1'b1, 99, 99);
    step(5'd0, 2'd0, 1'b0, 1'b1);
    chk("valid_clr_ce_low", int'(mix_valid), 0);

    // Fifty disabled clocks in the middle of slot 8.
    cur_md = vecs[5].md;
    push_exp(3066, 5110);
    run_frame(0, 17, 1'b1, 99, 8);

    // Reset in the middle of a frame, released at slot 9.
    cur_md = vecs[0].md;
    run_frame(0, 8, 1'b0, 99, 99);
    #3 reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("midrst_mel", int'(mix_melody), 0);
    chk("midrst_rhy", int'(mix_rhythm), 0);
    chk("midrst_maddr", int'(maddr), 0);
    chk("midrst_valid", int'(mix_valid), 0);
    reset = 1'b0;
    run_frame(9, 17, 1'b0, 99, 99);
    chk("partial_discard_mel", int'(mix_melody), 0);
    push_exp(900, 0);
    run_frame(0, 17, 1'b0, 99, 99);

    for (int k = 0; k < 3; k++) begin
      for (int s = 0; s < 18; s++) cur_md[s] = 10'($urandom_range(0, 1023));
      frr = 1'($urandom_range(0, 1));
      model(cur_md, frr, 14, m, r);
      model(cur_md, frr, 12, m12, r12);
      push_exp(m, r);
      run_frame(0, 17, frr, 99, 99);
      chk($sformatf("rand%0d_sat_mel", k), int'(mel12), m12);
      chk($sformatf("rand%0d_sat_rhy", k), int'(rhy12), r12);
    end

    step(5'd0, 2'd0, 1'b0, 1'b0);
    step(5'd0, 2'd0, 1'b0, 1'b0);
    chk("sb_drained", sbq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
